// File: rtl/src_datapath.sv
// Single-bus 32-bit CPU datapath: register file, special registers, store RAM,
// ALU and bus mux, all steered by an external control unit.
module src_datapath #(
  parameter int WIDTH     = 32,
  parameter int NREGS     = 16,
  parameter int RAM_DEPTH = 512
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              PCout,
  input  logic              ZLowout,
  input  logic              ZHighout,
  input  logic              MDRout,
  input  logic              HIout,
  input  logic              LOout,
  input  logic              Cout,
  input  logic              InPortOut,
  input  logic              BAout,
  input  logic              Rout,
  input  logic              MDRin,
  input  logic              MARin,
  input  logic              ZLowIn,
  input  logic              ZHighIn,
  input  logic              HIin,
  input  logic              LOin,
  input  logic              RAMin,
  input  logic              PCin,
  input  logic              IRin,
  input  logic              CONin,
  input  logic              Yin,
  input  logic              Rin,
  input  logic              OutPortIn,
  input  logic              InPortIn,
  input  logic              IncPC,
  input  logic              Read,
  input  logic              GRA,
  input  logic              GRB,
  input  logic              GRC,
  input  logic [NREGS-1:0]  REGin,
  input  logic [NREGS-1:0]  REGout,
  output logic [4:0]        opcode,
  input  logic [WIDTH-1:0]  Mdatain,
  input  logic [WIDTH-1:0]  InPort_data,
  output logic [WIDTH-1:0]  OutPort_data,
  output logic [WIDTH-1:0]  bus
);

  localparam int SELW = $clog2(NREGS);
  localparam int AW   = $clog2(RAM_DEPTH);
  localparam int SHW  = $clog2(WIDTH);

  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_SHR = 5'b00101;
  localparam logic [4:0] OP_SHL = 5'b00110;
  localparam logic [4:0] OP_ROR = 5'b00111;
  localparam logic [4:0] OP_ROL = 5'b01000;
  localparam logic [4:0] OP_AND = 5'b01001;
  localparam logic [4:0] OP_OR  = 5'b01010;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL = 5'b01110;
  localparam logic [4:0] OP_DIV = 5'b01111;
  localparam logic [4:0] OP_NEG = 5'b10000;
  localparam logic [4:0] OP_NOT = 5'b10001;

  logic [WIDTH-1:0]   r [NREGS];
  logic [WIDTH-1:0]   pc, ir, mar, mdr, y, hi, lo, in_port, out_port;
  logic [2*WIDTH-1:0] z;
  logic               con;
  logic [WIDTH-1:0]   ram [RAM_DEPTH];

  logic [SELW-1:0]    sel;
  logic [NREGS-1:0]   sel_dec, reg_we, reg_oe;
  logic               ba_zero;
  logic [WIDTH-1:0]   c_ext;
  logic [2*WIDTH-1:0] alu_res;
  logic               con_next;

  assign opcode       = ir[31:27];
  assign OutPort_data = out_port;
  assign c_ext        = {{(WIDTH-19){ir[18]}}, ir[18:0]};

  // Select-encode: the GR* strobes OR together the chosen IR register fields.
  assign sel     = ({SELW{GRA}} & ir[26:23]) | ({SELW{GRB}} & ir[22:19]) |
                   ({SELW{GRC}} & ir[18:15]);
  assign sel_dec = {{(NREGS-1){1'b0}}, 1'b1} << sel;
  assign reg_we  = REGin  | (sel_dec & {NREGS{Rin}});
  assign reg_oe  = REGout | (sel_dec & {NREGS{Rout | BAout}});
  // Base-address reads of R0 yield zero unless R0 is also driven normally.
  assign ba_zero = BAout && (sel == '0) && !Rout && !REGout[0];

  // Lowest-priority source is assigned first so higher-priority ones overwrite it.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    bus = '0;
    if (Cout)      bus = c_ext;
    if (InPortOut) bus = in_port;
    if (MDRout)    bus = mdr;
    if (PCout)     bus = pc;
    if (ZLowout)   bus = z[WIDTH-1:0];
    if (ZHighout)  bus = z[2*WIDTH-1:WIDTH];
    if (LOout)     bus = lo;
    if (HIout)     bus = hi;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (reg_oe[i]) bus = (i == 0 && ba_zero) ? '0 : r[i];
    end
  end

  always_comb begin
    logic [2*WIDTH-1:0]       dbl;
    logic [2*WIDTH-1:0]       dbl_l;
    logic signed [WIDTH-1:0]  quo, rem;
    logic [SHW-1:0]           sh;
    sh    = bus[SHW-1:0];
    dbl   = {y, y} >> sh;
    dbl_l = {y, y} << sh;
    quo   = '0;
    rem   = '0;
    if (bus != '0) begin
      quo = $signed(y) / $signed(bus);
      rem = $signed(y) % $signed(bus);
    end
    case (opcode)
      OP_SUB:          alu_res = {{WIDTH{1'b0}}, y - bus};
      OP_SHR:          alu_res = {{WIDTH{1'b0}}, y >> sh};
      OP_SHL:          alu_res = {{WIDTH{1'b0}}, y << sh};
      OP_ROR:          alu_res = {{WIDTH{1'b0}}, dbl[WIDTH-1:0]};
      OP_ROL:          alu_res = {{WIDTH{1'b0}}, dbl_l[2*WIDTH-1:WIDTH]};
      OP_AND, OP_ANDI: alu_res = {{WIDTH{1'b0}}, y & bus};
      OP_OR, OP_ORI:   alu_res = {{WIDTH{1'b0}}, y | bus};
      OP_MUL:          alu_res = {{WIDTH{y[WIDTH-1]}}, y} * {{WIDTH{bus[WIDTH-1]}}, bus};
      OP_DIV:          alu_res = {rem, quo};
      OP_NEG:          alu_res = {{WIDTH{1'b0}}, -bus};
      OP_NOT:          alu_res = {{WIDTH{1'b0}}, ~bus};
      default:         alu_res = {{WIDTH{1'b0}}, y + bus};
    endcase
  end

  always_comb begin
    case (ir[20:19])
      2'b00:   con_next = (bus == '0);
      2'b01:   con_next = (bus != '0);
      2'b10:   con_next = !bus[WIDTH-1];
      default: con_next = bus[WIDTH-1];
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      for (int i = 0; i < NREGS; i++) r[i] <= '0;
      pc       <= '0;
      ir       <= '0;
      mar      <= '0;
      mdr      <= '0;
      y        <= '0;
      z        <= '0;
      hi       <= '0;
      lo       <= '0;
      con      <= 1'b0;
      in_port  <= '0;
      out_port <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (reg_we[i]) r[i] <= bus;
      end
      if (PCin)      pc       <= IncPC ? pc + 1'b1 : bus;
      if (IRin)      ir       <= bus;
      if (MARin)     mar      <= bus;
      if (MDRin)     mdr      <= Read ? Mdatain : bus;
      if (Yin)       y        <= bus;
      if (HIin)      hi       <= bus;
      if (LOin)      lo       <= bus;
      if (OutPortIn) out_port <= bus;
      if (InPortIn)  in_port  <= InPort_data;
      if (CONin)     con      <= con_next;
      if (ZLowIn)    z[WIDTH-1:0]       <= alu_res[WIDTH-1:0];
      if (ZHighIn)   z[2*WIDTH-1:WIDTH] <= alu_res[2*WIDTH-1:WIDTH];
    end
  end

  // NOTE: the RAM array has no reset; clearing it would force a flop-based memory.
  always_ff @(posedge Clock) begin
    if (RAMin) ram[mar[AW-1:0]] <= mdr;
  end

endmodule

// File: tb/tb_src_datapath.sv
// Directed bench for src_datapath acting as the control unit; expected values
// are queued when a step is issued and compared once the DUT has responded.
module tb_src_datapath;

  logic        Clock = 1'b0;
  logic        Clear;
  logic        PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortOut, BAout, Rout;
  logic        MDRin, MARin, ZLowIn, ZHighIn, HIin, LOin, RAMin, PCin, IRin, CONin, Yin, Rin;
  logic        OutPortIn, InPortIn, IncPC, Read, GRA, GRB, GRC;
  logic [15:0] REGin, REGout;
  logic [4:0]  opcode;
  logic [31:0] Mdatain, InPort_data, OutPort_data, bus;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 Clock = ~Clock;

  src_datapath dut (
    .Clock(Clock), .Clear(Clear),
    .PCout(PCout), .ZLowout(ZLowout), .ZHighout(ZHighout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .Cout(Cout), .InPortOut(InPortOut),
    .BAout(BAout), .Rout(Rout),
    .MDRin(MDRin), .MARin(MARin), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn),
    .HIin(HIin), .LOin(LOin), .RAMin(RAMin), .PCin(PCin), .IRin(IRin),
    .CONin(CONin), .Yin(Yin), .Rin(Rin), .OutPortIn(OutPortIn), .InPortIn(InPortIn),
    .IncPC(IncPC), .Read(Read), .GRA(GRA), .GRB(GRB), .GRC(GRC),
    .REGin(REGin), .REGout(REGout), .opcode(opcode),
    .Mdatain(Mdatain), .InPort_data(InPort_data),
    .OutPort_data(OutPort_data), .bus(bus)
  );

  task automatic expect_val(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [63:0] observed);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed=%h expected=<queued value>", observed);
    end else begin
      e = sb_q.pop_front();
      assert (observed === e.val) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", e.tag, observed, e.val);
      end
    end
  endtask

  task automatic clear_ctrl();
    {PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortOut, BAout, Rout} = '0;
    {MDRin, MARin, ZLowIn, ZHighIn, HIin, LOin, RAMin, PCin, IRin, CONin, Yin, Rin} = '0;
    {OutPortIn, InPortIn, IncPC, Read, GRA, GRB, GRC} = '0;
    REGin  = '0;
    REGout = '0;
  endtask

  // Apply the current strobes across one rising edge, then drop them.
  task automatic step();
    @(posedge Clock);
    #1;
    clear_ctrl();
  endtask

  task automatic load_inport(input logic [31:0] v);
    InPort_data = v;
    InPortIn    = 1'b1;
    step();
  endtask

  task automatic load_ir(input logic [31:0] v);
    load_inport(v);
    InPortOut = 1'b1;
    IRin      = 1'b1;
    step();
  endtask

  task automatic run_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    load_ir({op, 27'b0});
    load_inport(a);
    InPortOut = 1'b1;
    Yin       = 1'b1;
    step();
    load_inport(b);
    InPortOut = 1'b1;
    ZLowIn    = 1'b1;
    ZHighIn   = 1'b1;
    step();
  endtask

  initial begin
    Clear       = 1'b0;
    Mdatain     = '0;
    InPort_data = '0;
    clear_ctrl();
    #2;
    expect_val("rst_opcode", 0);  check(opcode);
    expect_val("rst_bus", 0);     check(bus);
    expect_val("rst_outport", 0); check(OutPort_data);
    expect_val("rst_pc", 0);      check(dut.pc);
    @(negedge Clock);
    Clear = 1'b1;

    // Load PC=5 and R3=7, then reset asynchronously mid-cycle.
    load_inport(32'd5);
    InPortOut = 1'b1; PCin = 1'b1;
    step();
    load_inport(32'd7);
    InPortOut = 1'b1; REGin = 16'h0008;
    step();
    expect_val("pre_rst_pc", 5); check(dut.pc);
    expect_val("pre_rst_r3", 7); check(dut.r[3]);
    InPortOut = 1'b1;
    #2;
    Clear = 1'b0;
    #1;
    expect_val("async_pc", 0);     check(dut.pc);
    expect_val("async_r3", 0);     check(dut.r[3]);
    expect_val("async_bus", 0);    check(bus);
    expect_val("async_inport", 0); check(dut.in_port);
    clear_ctrl();
    @(negedge Clock);
    Clear = 1'b1;

    // Instruction fetch.
    Mdatain = 32'hA100_0000;
    PCout = 1'b1; MARin = 1'b1;
    step();
    expect_val("fetch_mar", 0); check(dut.mar);
    PCin = 1'b1; IncPC = 1'b1; Read = 1'b1; MDRin = 1'b1;
    step();
    expect_val("fetch_pc", 1);               check(dut.pc);
    expect_val("fetch_mdr", 64'hA100_0000);  check(dut.mdr);
    MDRout = 1'b1; IRin = 1'b1;
    step();
    expect_val("fetch_ir", 64'hA100_0000);   check(dut.ir);
    expect_val("fetch_opcode", 5'b10100);    check(opcode);

    // Link then jump through Ra (=R2).
    load_inport(32'h55);
    InPortOut = 1'b1; REGin = 16'h0004;
    step();
    PCout = 1'b1; REGin = 16'h8000;
    step();
    expect_val("link_r15", 1); check(dut.r[15]);
    GRA = 1'b1; Rout = 1'b1; PCin = 1'b1;
    #1;
    expect_val("jump_bus", 32'h55); check(bus);
    step();
    expect_val("jump_pc", 32'h55);  check(dut.pc);

    // ALU operations, Z holds the full 64-bit result.
    run_alu(5'b00000, 32'd6, 32'd7);
    expect_val("alu_add", 64'd13);                  check(dut.z);
    run_alu(5'b00100, 32'd6, 32'd7);
    expect_val("alu_sub", 64'h0000_0000_FFFF_FFFF); check(dut.z);
    run_alu(5'b01110, 32'hFFFF_FFFD, 32'd4);
    expect_val("alu_mul", 64'hFFFF_FFFF_FFFF_FFF4); check(dut.z);
    run_alu(5'b01111, 32'd7, 32'd2);
    expect_val("alu_div", 64'h0000_0001_0000_0003); check(dut.z);
    run_alu(5'b01111, 32'd7, 32'd0);
    expect_val("alu_div0", 64'd0);                  check(dut.z);
    run_alu(5'b10000, 32'd0, 32'd5);
    expect_val("alu_neg", 64'h0000_0000_FFFF_FFFB); check(dut.z);
    run_alu(5'b00111, 32'h0000_0001, 32'd1);
    expect_val("alu_ror", 64'h0000_0000_8000_0000); check(dut.z);
    run_alu(5'b01000, 32'h8000_0000, 32'd1);
    expect_val("alu_rol", 64'd1);                   check(dut.z);
    run_alu(5'b00101, 32'h8000_0000, 32'd31);
    expect_val("alu_shr", 64'd1);                   check(dut.z);

    // BAout on R0 and constant drive.
    load_inport(32'h1234);
    InPortOut = 1'b1; REGin = 16'h0001;
    step();
    load_ir(32'h0000_0000);
    GRB = 1'b1; BAout = 1'b1;
    #1;
    expect_val("baout_r0", 0);       check(bus);
    clear_ctrl();
    GRB = 1'b1; Rout = 1'b1;
    #1;
    expect_val("rout_r0", 32'h1234); check(bus);
    clear_ctrl();
    load_ir(32'h0007_FFFF);
    Cout = 1'b1;
    #1;
    expect_val("cout_neg", 32'hFFFF_FFFF); check(bus);
    clear_ctrl();
    load_ir(32'h0003_FFFF);
    Cout = 1'b1; REGout = 16'h0004;
    #1;
    expect_val("prio_r2_over_c", 32'h55);  check(bus);
    REGout = '0;
    #1;
    expect_val("cout_pos", 32'h0003_FFFF); check(bus);
    clear_ctrl();

    // CON and I/O ports.
    load_ir(32'h0000_0000);
    CONin = 1'b1;
    step();
    expect_val("con_eq0", 1); check(dut.con);
    load_inport(32'd9);
    InPortOut = 1'b1; OutPortIn = 1'b1; CONin = 1'b1;
    step();
    expect_val("outport", 9); check(OutPort_data);
    expect_val("con_ne0", 0); check(dut.con);
    load_ir(32'h0018_0000);
    load_inport(32'h8000_0000);
    InPortOut = 1'b1; CONin = 1'b1;
    step();
    expect_val("con_neg", 1); check(dut.con);

    // RAM store at MAR[8:0].
    load_inport(32'h0000_0203);
    InPortOut = 1'b1; MARin = 1'b1;
    step();
    load_inport(32'hDEAD_BEEF);
    InPortOut = 1'b1; MDRin = 1'b1;
    step();
    RAMin = 1'b1;
    step();
    expect_val("ram_store", 32'hDEAD_BEEF); check(dut.ram[3]);

    if (sb_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover: observed=%0d expected=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
